// File: rtl/sc_fetch_unit_pkg.sv
// Shared encodings for the fetch stage: FSM state codes, pcsource codes (same
// encoding as the control unit) and the NOP word driven when no instruction is live.
package sc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_JR  = 2'b10,
    PCSRC_J   = 2'b11
  } pcsrc_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/sc_fetch_wdog.sv
// Request watchdog: counts REQ cycles without ack; expire is high once the count
// reaches TIMEOUT-1. Clear has priority; the counter parks at the expire value.
module sc_fetch_wdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/sc_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake, holds the
// instruction while stall is high. Best case 2 cycles/instruction; latency = ack cycle + 1.
module sc_fetch_unit
  import sc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] ra,
  input  logic [31:0] jpc,
  output logic [31:0] inst,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        fetch_err
);

  state_t      state;
  logic [31:0] npc;
  logic        wdog_clear;
  logic        wdog_enable;
  logic        wdog_expire;

  assign pc4       = pc + 32'd4;
  assign imem_addr = pc;
  assign op        = inst[31:26];
  assign func      = inst[5:0];

  always_comb begin
    npc = pc4;
    case (pcsrc_t'(pcsource))
      PCSRC_BR: npc = bpc;
      PCSRC_JR: npc = ra;
      PCSRC_J:  npc = jpc;
      default:  npc = pc4;
    endcase
  end

  // Watchdog runs only while a request is outstanding and restarts on every ack.
  assign wdog_clear  = (state != ST_REQ) || imem_ack;
  assign wdog_enable = (state == ST_REQ) && !imem_ack;

  sc_fetch_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (wdog_clear),
    .enable (wdog_enable),
    .expire (wdog_expire)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      inst       <= NOP;
      inst_valid <= 1'b0;
      imem_req   <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_REQ;
          imem_req <= 1'b1;
        end
        ST_REQ: begin
          if (imem_ack) begin
            inst       <= imem_rdata;
            inst_valid <= 1'b1;
            imem_req   <= 1'b0;
            state      <= ST_HOLD;
          end else if (wdog_expire) begin
            imem_req  <= 1'b0;
            fetch_err <= 1'b1;
            state     <= ST_ERR;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            inst       <= NOP;
            inst_valid <= 1'b0;
            // A misaligned target never reaches the PC: the faulting pc stays visible.
            if (!is_aligned(npc[1:0])) begin
              fetch_err <= 1'b1;
              state     <= ST_ERR;
            end else begin
              pc       <= npc;
              imem_req <= 1'b1;
              state    <= ST_REQ;
            end
          end
        end
        default: begin
          state      <= ST_ERR;
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
          inst       <= NOP;
          fetch_err  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_fetch_unit.sv
// Self-checking bench for sc_fetch_unit: directed scenarios plus a randomized run
// against a PC/instruction reference model kept in the bench.
module tb_sc_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic [1:0]  pcsource;
  logic [31:0] bpc, ra, jpc;
  logic [31:0] inst;
  logic [5:0]  op, func;
  logic        inst_valid;
  logic [31:0] pc, pc4;
  logic        fetch_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;

  always #5 clock = ~clock;

  sc_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .ra         (ra),
    .jpc        (jpc),
    .inst       (inst),
    .op         (op),
    .func       (func),
    .inst_valid (inst_valid),
    .pc         (pc),
    .pc4        (pc4),
    .fetch_err  (fetch_err)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; imem_ack = 1'b0; stall = 1'b0; pcsource = 2'b00;
    bpc = 32'h0; ra = 32'h0; jpc = 32'h0; imem_rdata = 32'h0;
    step(); step();
    reset = 1'b0;
    exp_pc = 32'h0;
  endtask

  // Stimulus only: present an ack with word w on the next edge.
  task automatic give_ack(input logic [31:0] w);
    imem_rdata = w; imem_ack = 1'b1;
    step();
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset();
    do_reset();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    checks++; if ({imem_req, inst_valid, fetch_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {imem_req, inst_valid, fetch_err}); end
    checks++; if (inst !== 32'h0 || pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc got inst=%h pc=%h want 0/0", inst, pc); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    checks++; if (inst_valid !== 1'b0 || inst !== 32'h0) begin errors++; $display("FAIL idle_ack_ignored got valid=%b inst=%h want 0/0", inst_valid, inst); end
  endtask

  task automatic test_seq();
    imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
    step();
    imem_ack = 1'b0;
    checks++; if (inst_valid !== 1'b1 || op !== 6'b001000 || func !== 6'b000101 || inst !== 32'h2008_0005) begin errors++; $display("FAIL seq_decode got valid=%b op=%b func=%b inst=%h want 1/001000/000101/20080005", inst_valid, op, func, inst); end
    checks++; if (imem_req !== 1'b0 || pc !== 32'h0 || pc4 !== 32'h4) begin errors++; $display("FAIL seq_hold got req=%b pc=%h pc4=%h want 0/0/4", imem_req, pc, pc4); end
    stall = 1'b0; pcsource = 2'b00;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || inst_valid !== 1'b0) begin errors++; $display("FAIL seq_next got req=%b addr=%h valid=%b want 1/4/0", imem_req, imem_addr, inst_valid); end
    exp_pc = 32'h4;
  endtask

  task automatic test_targets();
    logic [31:0] tgt [3];
    tgt[0] = 32'h40; tgt[1] = 32'h100; tgt[2] = 32'h200;
    for (int k = 0; k < 3; k++) begin
      give_ack(32'h1000_0000 + 32'(k));
      checks++; if (pc !== exp_pc || pc4 !== exp_pc + 32'd4) begin errors++; $display("FAIL tgt%0d_pc4 got pc=%h pc4=%h want %h/%h", k, pc, pc4, exp_pc, exp_pc + 32'd4); end
      pcsource = 2'(k + 1);
      bpc = 32'h0000_0FF1; ra = 32'h0000_0FF2; jpc = 32'h0000_0FF3;
      if (k == 0) bpc = tgt[k];
      if (k == 1) ra  = tgt[k];
      if (k == 2) jpc = tgt[k];
      step();
      exp_pc = tgt[k];
      checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc || fetch_err !== 1'b0) begin errors++; $display("FAIL tgt%0d_addr got req=%b addr=%h err=%b want 1/%h/0", k, imem_req, imem_addr, fetch_err, exp_pc); end
    end
    pcsource = 2'b00;
  endtask

  task automatic test_stall();
    give_ack(32'hABCD_1234);
    stall = 1'b1; pcsource = 2'b11; jpc = 32'h0000_0800;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (inst !== 32'hABCD_1234 || pc !== exp_pc || inst_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL stall%0d got inst=%h pc=%h valid=%b req=%b want abcd1234/%h/1/0", c, inst, pc, inst_valid, imem_req, exp_pc); end
    end
    stall = 1'b0; pcsource = 2'b00;
    step();
    exp_pc = exp_pc + 32'd4;
    checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin errors++; $display("FAIL stall_release got req=%b addr=%h want 1/%h", imem_req, imem_addr, exp_pc); end
  endtask

  task automatic test_random();
    int          d, s;
    logic [31:0] w;
    for (int it = 0; it < 40; it++) begin
      d = (it % 8 == 7) ? int'($urandom_range(10, 14)) : int'($urandom_range(0, 4));
      w = $urandom;
      imem_ack = 1'b0;
      for (int c = 0; c < d; c++) begin
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc || inst_valid !== 1'b0 || fetch_err !== 1'b0) begin errors++; $display("FAIL rnd%0d_wait got req=%b addr=%h valid=%b err=%b want 1/%h/0/0", it, imem_req, imem_addr, inst_valid, fetch_err, exp_pc); end
      end
      give_ack(w);
      checks++; if ({inst, inst_valid, pc, pc4, imem_req} !== {w, 1'b1, exp_pc, exp_pc + 32'd4, 1'b0}) begin errors++; $display("FAIL rnd%0d_fetch got inst=%h valid=%b pc=%h pc4=%h req=%b want %h/1/%h/%h/0", it, inst, inst_valid, pc, pc4, imem_req, w, exp_pc, exp_pc + 32'd4); end
      s = int'($urandom_range(0, 3));
      stall = 1'b1;
      for (int c = 0; c < s; c++) begin
        pcsource = 2'($urandom_range(0, 3)); bpc = $urandom; ra = $urandom; jpc = $urandom;
        step();
        checks++; if (inst !== w || pc !== exp_pc || inst_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL rnd%0d_stall got inst=%h pc=%h valid=%b req=%b want %h/%h/1/0", it, inst, pc, inst_valid, imem_req, w, exp_pc); end
      end
      stall = 1'b0;
      pcsource = 2'($urandom_range(0, 3)); bpc = $urandom; ra = $urandom; jpc = $urandom;
      case (pcsource)
        2'b00: exp_pc = exp_pc + 32'd4;
        2'b01: begin bpc = bpc & 32'hFFFF_FFFC; exp_pc = bpc; end
        2'b10: begin ra  = ra  & 32'hFFFF_FFFC; exp_pc = ra;  end
        default: begin jpc = jpc & 32'hFFFF_FFFC; exp_pc = jpc; end
      endcase
      step();
      checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc || inst_valid !== 1'b0 || inst !== 32'h0) begin errors++; $display("FAIL rnd%0d_npc got req=%b addr=%h valid=%b inst=%h want 1/%h/0/0", it, imem_req, imem_addr, inst_valid, inst, exp_pc); end
    end
    pcsource = 2'b00;
  endtask

  task automatic test_reset_mid_req();
    imem_ack = 1'b1; reset = 1'b1;
    step();
    checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL reset_mid_req got req=%b valid=%b pc=%h want 0/0/0", imem_req, inst_valid, pc); end
    reset = 1'b0; imem_ack = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    step();
    for (int k = 1; k <= 15; k++) begin
      step();
      checks++; if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL timeout_early%0d got err=%b req=%b want 0/1", k, fetch_err, imem_req); end
    end
    step();
    checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL timeout_fire got err=%b req=%b valid=%b want 1/0/0", fetch_err, imem_req, inst_valid); end
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    repeat (3) step();
    checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0) begin errors++; $display("FAIL timeout_sticky got err=%b req=%b valid=%b inst=%h want 1/0/0/0", fetch_err, imem_req, inst_valid, inst); end
    do_reset();
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL err_cleared got %b want 0", fetch_err); end
    step();
    repeat (14) step();
    give_ack(32'h8C01_0004);
    checks++; if (fetch_err !== 1'b0 || inst_valid !== 1'b1 || inst !== 32'h8C01_0004) begin errors++; $display("FAIL ack15 got err=%b valid=%b inst=%h want 0/1/8c010004", fetch_err, inst_valid, inst); end
  endtask

  task automatic test_misalign();
    do_reset();
    step();
    give_ack(32'h0000_0008);
    pcsource = 2'b10; ra = 32'h0000_0102;
    step();
    checks++; if (fetch_err !== 1'b1 || inst_valid !== 1'b0 || inst !== 32'h0 || imem_req !== 1'b0) begin errors++; $display("FAIL misalign got err=%b valid=%b inst=%h req=%b want 1/0/0/0", fetch_err, inst_valid, inst, imem_req); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL misalign_pc got %h want 0", pc); end
    pcsource = 2'b00;
    repeat (2) step();
    checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL misalign_sticky got err=%b req=%b pc=%h want 1/0/0", fetch_err, imem_req, pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    step();
    give_ack(32'h0);
    pcsource = 2'b11; jpc = 32'hFFFF_FFFC;
    step();
    checks++; if (imem_addr !== 32'hFFFF_FFFC || imem_req !== 1'b1) begin errors++; $display("FAIL wrap_jump got addr=%h req=%b want fffffffc/1", imem_addr, imem_req); end
    give_ack(32'h0C00_0000);
    checks++; if (pc4 !== 32'h0 || op !== 6'b000011) begin errors++; $display("FAIL wrap_pc4 got pc4=%h op=%b want 0/000011", pc4, op); end
    pcsource = 2'b00;
    step();
    checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1 || fetch_err !== 1'b0) begin errors++; $display("FAIL wrap_seq got addr=%h req=%b err=%b want 0/1/0", imem_addr, imem_req, fetch_err); end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_targets();
    test_stall();
    test_random();
    test_reset_mid_req();
    test_timeout();
    test_misalign();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1);
  end

endmodule
